// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM with frame-aligned angle updates and slew limiting
//
// Optional feature macro: SERVO_PWM_MULTI_WATCHDOG_EN
//   When defined, all channels are released (pulse width 0) after WD_FRAMES
//   frame boundaries without an accepted command.
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-high
//   enable       advances the prescaler and frame counters
//   angle_in     NUM_CH packed angle commands, channel i at [i*ANGLE_W +: ANGLE_W]
//   angle_valid  angle_in is valid
//   angle_ready  pending buffer is empty
//   pwm          registered servo pulse outputs
//   frame_start  one-clock pulse when a new frame begins
`timescale 1ns/1ps
module servo_pwm_multi #(
  parameter int NUM_CH = 2,
  parameter int ANGLE_W = 12,
  parameter int CLK_DIV = 65,
  parameter int TICK_W = 14,
  parameter int PERIOD_TICKS = 16384,
  parameter int SERVOMIN = 500,
  parameter int SERVOMAX = 2600,
  parameter logic [NUM_CH-1:0] REVERSED_MASK = '0,
  parameter int SLEW_STEP = 0,
  parameter int WD_FRAMES = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_CH*ANGLE_W-1:0] angle_in,
  input  logic                      angle_valid,
  output logic                      angle_ready,
  output logic [NUM_CH-1:0]         pwm,
  output logic                      frame_start
);

  localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PROD_W = ANGLE_W + $clog2(SERVOMAX) + 1;
  localparam logic [PROD_W-1:0] SPAN = PROD_W'(SERVOMAX - SERVOMIN);
  localparam logic [TICK_W-1:0] STEP = TICK_W'(SLEW_STEP);

  logic [PS_W-1:0]   prescaler;
  logic [TICK_W-1:0] tick;
  logic              tick_en;
  logic              boundary;
  logic              accept;
  logic              pend_full;
  logic              wd_fire;
  logic              fs_q;
  logic [NUM_CH-1:0] pwm_q;

  logic [TICK_W-1:0] pend        [NUM_CH];
  logic [TICK_W-1:0] target      [NUM_CH];
  logic [TICK_W-1:0] active      [NUM_CH];
  logic [TICK_W-1:0] cap_width   [NUM_CH];
  logic [TICK_W-1:0] next_target [NUM_CH];
  logic [TICK_W-1:0] next_active [NUM_CH];

  // Angle to pulse width; the product is kept at full precision before the shift.
  function automatic logic [TICK_W-1:0] map_angle(input logic [ANGLE_W-1:0] angle,
                                                   input logic rev);
    logic [PROD_W-1:0] off;
    off = (SPAN * PROD_W'(angle)) >> ANGLE_W;
    if (rev) map_angle = TICK_W'(PROD_W'(SERVOMAX) - off);
    else     map_angle = TICK_W'(PROD_W'(SERVOMIN) + off);
  endfunction

  // A channel at width 0 has never been commanded (or was released), so it jumps.
  function automatic logic [TICK_W-1:0] step_toward(input logic [TICK_W-1:0] cur,
                                                     input logic [TICK_W-1:0] tgt);
    logic [TICK_W-1:0] diff;
    diff = '0;
    step_toward = tgt;
    if (SLEW_STEP != 0 && cur != '0) begin
      if (tgt > cur) begin
        diff = tgt - cur;
        if (diff > STEP) step_toward = cur + STEP;
      end else begin
        diff = cur - tgt;
        if (diff > STEP) step_toward = cur - STEP;
      end
    end
  endfunction

  assign tick_en     = enable && (prescaler == PS_W'(CLK_DIV - 1));
  assign boundary    = tick_en && (tick == TICK_W'(PERIOD_TICKS - 1));
  assign angle_ready = ~pend_full;
  assign accept      = angle_valid && ~pend_full;
  assign pwm         = pwm_q;
  assign frame_start = fs_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cap_width[i]   = map_angle(angle_in[i*ANGLE_W +: ANGLE_W], REVERSED_MASK[i]);
      // Uses the buffer state registered before this cycle, so a capture in
      // the boundary cycle waits for the following boundary.
      next_target[i] = pend_full ? pend[i] : target[i];
      next_active[i] = step_toward(active[i], next_target[i]);
    end
  end

`ifdef SERVO_PWM_MULTI_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_FRAMES + 1);
  logic [WD_W-1:0] wd_cnt;

  // An accepted command in the boundary cycle counts as activity and suppresses release.
  assign wd_fire = boundary && !accept && (wd_cnt >= WD_W'(WD_FRAMES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (accept) begin
      wd_cnt <= '0;
    end else if (boundary && (wd_cnt != WD_W'(WD_FRAMES))) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  logic unused_wd;
  assign unused_wd = (WD_FRAMES == 0);
  assign wd_fire   = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      tick      <= '0;
      pend_full <= 1'b0;
      fs_q      <= 1'b0;
      pwm_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pend[i]   <= '0;
        target[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (enable) prescaler <= tick_en ? '0 : prescaler + 1'b1;
      if (tick_en) tick <= boundary ? '0 : tick + 1'b1;
      fs_q <= boundary;

      if (accept) begin
        pend_full <= 1'b1;
        for (int i = 0; i < NUM_CH; i++) pend[i] <= cap_width[i];
      end else if (boundary && pend_full) begin
        pend_full <= 1'b0;
      end

      if (boundary) begin
        for (int i = 0; i < NUM_CH; i++) begin
          target[i] <= wd_fire ? '0 : next_target[i];
          active[i] <= wd_fire ? '0 : next_active[i];
        end
      end

      for (int i = 0; i < NUM_CH; i++) pwm_q[i] <= (tick < active[i]);
    end
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb/tb_servo_pwm_multi.sv - directed self-checking bench for servo_pwm_multi
`timescale 1ns/1ps
module tb_servo_pwm_multi;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] angle_bus = '0;
  logic        valid_a = 1'b0, valid_b = 1'b0, valid_w = 1'b0;
  logic        ready_a, ready_b, ready_w;
  logic [1:0]  pwm_a, pwm_b, pwm_w;
  logic        fs_a, fs_b, fs_w;

  int total = 0;
  int bad = 0;
  int sel = 0;
  logic [1:0] pwm_s;
  logic       ready_s;

  assign pwm_s   = (sel == 0) ? pwm_a : (sel == 1) ? pwm_b : pwm_w;
  assign ready_s = (sel == 0) ? ready_a : (sel == 1) ? ready_b : ready_w;

  always #5 clock = ~clock;

  servo_pwm_multi #(.NUM_CH(2), .ANGLE_W(8), .CLK_DIV(2), .TICK_W(8), .PERIOD_TICKS(100),
                    .SERVOMIN(10), .SERVOMAX(50), .REVERSED_MASK(2'b00), .SLEW_STEP(0),
                    .WD_FRAMES(64))
  dut_a (.clock(clock), .reset(reset), .enable(enable), .angle_in(angle_bus),
         .angle_valid(valid_a), .angle_ready(ready_a), .pwm(pwm_a), .frame_start(fs_a));

  servo_pwm_multi #(.NUM_CH(2), .ANGLE_W(8), .CLK_DIV(2), .TICK_W(8), .PERIOD_TICKS(100),
                    .SERVOMIN(10), .SERVOMAX(50), .REVERSED_MASK(2'b10), .SLEW_STEP(4),
                    .WD_FRAMES(64))
  dut_b (.clock(clock), .reset(reset), .enable(enable), .angle_in(angle_bus),
         .angle_valid(valid_b), .angle_ready(ready_b), .pwm(pwm_b), .frame_start(fs_b));

  servo_pwm_multi #(.NUM_CH(2), .ANGLE_W(8), .CLK_DIV(2), .TICK_W(8), .PERIOD_TICKS(100),
                    .SERVOMIN(10), .SERVOMAX(50), .REVERSED_MASK(2'b00), .SLEW_STEP(4),
                    .WD_FRAMES(3))
  dut_w (.clock(clock), .reset(reset), .enable(enable), .angle_in(angle_bus),
         .angle_valid(valid_w), .angle_ready(ready_w), .pwm(pwm_w), .frame_start(fs_w));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; valid_w = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_pwm", {pwm_w, pwm_b, pwm_a}, 0);
    check("rst_fs", {fs_w, fs_b, fs_a}, 0);
    check("rst_ready", {ready_w, ready_b, ready_a}, 3'b111);
    reset = 1'b0;
  endtask

  task automatic send(input string tag, input int a0, input int a1);
    angle_bus = {8'(a1), 8'(a0)};
    valid_a = (sel == 0); valid_b = (sel == 1); valid_w = (sel == 2);
    @(negedge clock);
    valid_a = 1'b0; valid_b = 1'b0; valid_w = 1'b0;
    check(tag, ready_s, 0);
  endtask

  // Starts at a negedge where frame_start is high (waiting for one if needed)
  // and samples one whole frame; returns at the next frame_start negedge.
  task automatic frame(input string tag, input int e0, input int e1);
    int n, c0, c1, nfs;
    n = 0; c0 = 0; c1 = 0; nfs = 0;
    while (fs_a !== 1'b1 && n < 500) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_fswait"}, fs_a, 1);
    for (int i = 0; i < 200; i++) begin
      c0 += int'(pwm_s[0]);
      c1 += int'(pwm_s[1]);
      nfs += int'(fs_a);
      @(negedge clock);
    end
    check({tag, "_ch0"}, c0, e0);
    check({tag, "_ch1"}, c1, e1);
    check({tag, "_nfs"}, nfs, 1);
  endtask

  task automatic count_to_fs(output int c0, output int c1);
    int n;
    n = 0; c0 = 0; c1 = 0;
    while (n < 500) begin
      @(negedge clock);
      n++;
      if (fs_a === 1'b1) break;
      c0 += int'(pwm_s[0]);
      c1 += int'(pwm_s[1]);
    end
    check("to_fs_wait", fs_a, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, c1, t0, t1, fs_seen;

    // Phase A: plain channels, no slew.
    sel = 0;
    do_reset();
    frame("idle1", 0, 0);
    frame("idle2", 0, 0);
    frame("idle3", 0, 0);
    check("idle_ready", ready_a, 1);

    // Mid-frame command: current frame untouched, next frame shows 30 and 49 ticks.
    repeat (50) @(negedge clock);
    send("cmd1_ready", 128, 255);
    count_to_fs(c0, c1);
    check("cur_frame_ch0", c0, 0);
    check("cur_frame_ch1", c1, 0);
    check("ready_back", ready_a, 1);
    frame("cmd1", 60, 98);

    // Capture in the boundary cycle (199 clocks after frame_start).
    repeat (199) @(negedge clock);
    angle_bus = {8'd128, 8'd255};
    valid_a = 1'b1;
    @(negedge clock);
    check("bnd_fs", fs_a, 1);
    check("bnd_ready", ready_a, 0);
    angle_bus = {8'd0, 8'd0};
    c0 = int'(pwm_a[0]); c1 = int'(pwm_a[1]);
    @(negedge clock);
    valid_a = 1'b0;
    check("ignored_ready", ready_a, 0);
    c0 += int'(pwm_a[0]); c1 += int'(pwm_a[1]);
    count_to_fs(t0, t1);
    check("bnd_old_ch0", c0 + t0, 60);
    check("bnd_old_ch1", c1 + t1, 98);
    frame("bnd_new", 98, 60);

    // Freeze for 50 clocks mid-pulse; the frame width must come out unchanged.
    c0 = 0; c1 = 0;
    for (int i = 0; i < 20; i++) begin
      c0 += int'(pwm_a[0]); c1 += int'(pwm_a[1]);
      @(negedge clock);
    end
    c0 += int'(pwm_a[0]); c1 += int'(pwm_a[1]);
    enable = 1'b0;
    fs_seen = 0;
    repeat (50) begin
      @(negedge clock);
      fs_seen += int'(fs_a);
    end
    check("freeze_pwm", pwm_a, 2'b11);
    check("freeze_fs", fs_seen, 0);
    enable = 1'b1;
    count_to_fs(t0, t1);
    check("freeze_ch0", c0 + t0, 98);
    check("freeze_ch1", c1 + t1, 60);

    // Asynchronous reset in the middle of a pulse.
    repeat (10) @(negedge clock);
    check("pre_rst_pwm", pwm_a, 2'b11);
    reset = 1'b1;
    #1;
    check("async_rst_pwm", pwm_a, 0);

    // Phase B: ch1 reversed, slew step 4.
    sel = 1;
    do_reset();
    send("rev0_ready", 0, 0);
    frame("rev0", 20, 100);
    do_reset();
    send("slew_init_ready", 128, 0);
    frame("slew_init", 60, 100);
    send("slew_cmd_ready", 255, 128);
    frame("slew1", 68, 92);
    frame("slew2", 76, 84);
    frame("slew3", 84, 76);
    frame("slew4", 92, 68);
    frame("slew5", 98, 60);
    frame("slew6", 98, 60);

`ifdef SERVO_PWM_MULTI_WATCHDOG_EN
    // Phase C: watchdog releases after 3 idle boundaries; next command jumps.
    sel = 2;
    do_reset();
    send("wd_cmd_ready", 128, 0);
    frame("wd_f1", 60, 20);
    frame("wd_f2", 60, 20);
    frame("wd_f3", 0, 0);
    send("wd_re_ready", 128, 255);
    frame("wd_jump", 60, 98);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
- Multi-channel servo PWM generator: NUM_CH outputs share one prescaler and one frame counter.
- Each channel has an independent angle-to-pulse mapping, an optional direction reversal and a slew-rate limit.
- Angle commands enter through a valid/ready handshake into a one-deep pending buffer. They take effect only at a frame boundary, so a pulse is never truncated or glitched.
- Sits between the balance controller (angle outputs) and the plate servos; replaces per-servo PWM instances.

Parameters:
- NUM_CH, 2, number of servo channels.
- ANGLE_W, 12, width of each angle command (full scale = 2^ANGLE_W - 1).
- CLK_DIV, 65, clock cycles per tick (65 gives 1 us).
- TICK_W, 14, width of the tick counter.
- PERIOD_TICKS, 16384, ticks per frame; must be <= 2^TICK_W.
- SERVOMIN, 500, pulse width in ticks at angle 0.
- SERVOMAX, 2600, pulse width in ticks at full scale; must be > SERVOMIN and < PERIOD_TICKS.
- REVERSED_MASK, 0, NUM_CH bits; bit i set reverses channel i.
- SLEW_STEP, 0, maximum change of pulse width per frame in ticks; 0 = unlimited.
- WD_FRAMES, 64, watchdog timeout in frames (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  advances prescaler and frame counters when high.
- angle_in  in  NUM_CH*ANGLE_W  channel i occupies bits [i*ANGLE_W +: ANGLE_W].
- angle_valid  in  1  angle_in is valid.
- angle_ready  out  1  pending buffer is empty.
- pwm  out  NUM_CH  servo pulse outputs, registered.
- frame_start  out  1  one-clock pulse when a new frame begins.

Behaviour:
Reset values:
- prescaler = 0, tick = 0.
- pending buffer empty; angle_ready = 1.
- target[i] = 0, active[i] = 0.
- pwm = 0, frame_start = 0.

Timing:
- Prescaler counts 0..CLK_DIV-1 while enable = 1; "tick" occurs in the cycle where it equals CLK_DIV-1.
- On a tick, tick counter increments; it wraps from PERIOD_TICKS-1 to 0.
- The wrap cycle is the frame boundary. frame_start is registered and is high for exactly one clock in the cycle after the counter reaches 0.
- enable = 0: prescaler, tick counter, pwm and active[] hold; no frame boundaries occur.

Mapping (per channel, on acceptance):
- off = ((SERVOMAX-SERVOMIN) * angle) >> ANGLE_W, full-precision product of width ANGLE_W + clog2(SERVOMAX) + 1.
- width = SERVOMIN + off normally; SERVOMAX - off when the channel's REVERSED_MASK bit is set.
- Result is TICK_W bits, stored in the pending buffer.

Handshake:
- Transfer occurs when angle_valid & angle_ready; all channels are captured together. angle_ready drops the next cycle.
- Handshaking works while enable = 0.
- angle_valid while not ready: ignored; the controller must hold.

Frame boundary:
- If the pending buffer is full (as registered before this cycle), target <= pending, the buffer empties, and angle_ready returns to 1 next cycle.
- A capture in the same cycle as a boundary is not applied until the following boundary.
- For each channel, active[i] moves toward the new target:
  - if SLEW_STEP = 0, or active[i] = 0 (first command): active[i] <= target (jump);
  - else active[i] moves by min(SLEW_STEP, |target - active|) toward target. No overshoot.

Output:
- pwm[i] <= (tick < active[i]), registered, one clock latency from the counters.
- active = 0 gives constant low.

Optional Feature:
- Macro: SERVO_PWM_MULTI_WATCHDOG_EN.
- Defined:
  - A frame counter clears on every accepted command and increments on each frame boundary, saturating.
  - When it reaches WD_FRAMES, at that boundary all active[i] and target[i] are set to 0, so pwm goes low (servo released).
  - The next accepted command jumps directly (first-command rule).
- Undefined: no watchdog logic; the last command is held indefinitely.

Test Plan:
Bench parameters: CLK_DIV=2, PERIOD_TICKS=100, TICK_W=8, SERVOMIN=10, SERVOMAX=50, ANGLE_W=8, NUM_CH=2.
1. Reset, no command -> pwm = 00 for 3 frames, angle_ready = 1, frame_start pulse every 200 clocks.
2. Send ch0=128, ch1=255 mid-frame -> angle_ready low until the next boundary; next frame ch0 high 30 ticks (60 clocks), ch1 high 49 ticks; the current frame is unaffected.
3. REVERSED_MASK=2'b10, ch1=0 -> ch1 high 50 ticks; ch0=0 -> 10 ticks.
4. SLEW_STEP=4, ch0 at 30, then command 255 -> successive frame widths 34, 38, 42, 46, 49, then 49 steady.
5. angle_valid asserted in the boundary cycle with the buffer empty -> applied one frame later; a second valid while ready = 0 is ignored. Deassert enable for 50 clocks -> pwm and counters freeze, then resume without a width change.
6. Watchdog (macro defined, WD_FRAMES=3): no command for 3 frames -> pwm = 00 from the third boundary; a new command of 128 -> 30-tick pulse the next frame with no slew. Assert reset mid-pulse -> pwm = 0 immediately.
